// File: rtl/scarv_cop_dispatch.sv
// Instruction dispatch controller for the crypto co-processor.
//
// Accepts one encoded ISE instruction at a time from the CPU and presents it
// to the combinational decoder. It then checks the decode result against the
// per-class feature enables and issues the instruction to the functional unit
// selected by the decoded class. It waits for that unit's done strobe or a
// watchdog timeout, then returns a status/result response to the CPU.
//
// Ports:
//   g_clk, g_reset        clock, asynchronous active-high reset
//   cpu_req_*             request handshake from the CPU (encoded instruction)
//   cpu_rsp_*             response handshake to the CPU (status, GPR write)
//   cpu_flush             abandon the in-flight instruction, no response
//   id_*                  decoder interface (encoded out, exception/class in)
//   mccr_en               per-class feature enables
//   fu_ivalid             one-hot issue strobe, bit k = class k
//   fu_done/fu_exception/fu_gpr_*  completion info from the functional units
//
// Every output is a register or a decode of registered state only.

module scarv_cop_dispatch #(
  parameter int unsigned TIMEOUT = 255  // cycles to wait for fu_done, 1..255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_encoded,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [2:0]  cpu_rsp_status,
  output logic [31:0] cpu_rsp_wdata,
  output logic        cpu_rsp_wen,
  input  logic        cpu_flush,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [2:0]  id_class,
  input  logic [7:0]  mccr_en,
  output logic [7:0]  fu_ivalid,
  input  logic [7:0]  fu_done,
  input  logic        fu_exception,
  input  logic        fu_gpr_wen,
  input  logic [31:0] fu_gpr_wdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [2:0] StatusOk       = 3'd0;
  localparam logic [2:0] StatusIllegal  = 3'd1;
  localparam logic [2:0] StatusDisabled = 3'd2;
  localparam logic [2:0] StatusFuExc    = 3'd3;
  localparam logic [2:0] StatusTimeout  = 3'd4;

  // Last timer value before the watchdog fires; the timer saturates here.
  localparam logic [7:0] TimerMax = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [2:0]  cls_q, cls_d;
  logic [7:0]  timer_q, timer_d;
  logic [2:0]  status_q, status_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    cls_d    = cls_q;
    timer_d  = timer_q;
    status_d = status_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;

    if (cpu_flush) begin
      // Flush beats every other event, including a request arriving in IDLE.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_req_valid) begin
            insn_d  = cpu_req_encoded;
            state_d = StDecode;
          end
        end
        StDecode: begin
          if (id_exception) begin
            status_d = StatusIllegal;
            wen_d    = 1'b0;
            wdata_d  = '0;
            state_d  = StResp;
          end else if (!mccr_en[id_class]) begin
            status_d = StatusDisabled;
            wen_d    = 1'b0;
            wdata_d  = '0;
            state_d  = StResp;
          end else begin
            cls_d   = id_class;
            timer_d = '0;
            state_d = StExec;
          end
        end
        StExec: begin
          timer_d = (timer_q == TimerMax) ? timer_q : timer_q + 8'd1;
          // Done is checked first so it wins over a coincident timeout.
          if (fu_done[cls_q]) begin
            status_d = fu_exception ? StatusFuExc : StatusOk;
            wen_d    = fu_gpr_wen & ~fu_exception;
            wdata_d  = (fu_gpr_wen & ~fu_exception) ? fu_gpr_wdata : '0;
            state_d  = StResp;
          end else if (timer_q == TimerMax) begin
            status_d = StatusTimeout;
            wen_d    = 1'b0;
            wdata_d  = '0;
            state_d  = StResp;
          end
        end
        StResp: begin
          if (cpu_rsp_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= StIdle;
      insn_q   <= '0;
      cls_q    <= '0;
      timer_q  <= '0;
      status_q <= StatusOk;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      insn_q   <= insn_d;
      cls_q    <= cls_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cpu_req_ready  = (state_q == StIdle);
  assign cpu_rsp_valid  = (state_q == StResp);
  assign cpu_rsp_status = status_q;
  assign cpu_rsp_wen    = wen_q;
  assign cpu_rsp_wdata  = wdata_q;
  assign id_encoded     = insn_q;
  assign fu_ivalid      = (state_q == StExec) ? (8'd1 << cls_q) : 8'd0;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Self-checking bench for scarv_cop_dispatch: directed scenarios plus a
// randomized run scored against a transaction-level reference model.

module tb_scarv_cop_dispatch;

  localparam int unsigned T = 4;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_encoded;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready;
  logic [2:0]  cpu_rsp_status;
  logic [31:0] cpu_rsp_wdata;
  logic        cpu_rsp_wen;
  logic        cpu_flush;
  logic [31:0] id_encoded;
  logic        id_exception;
  logic [2:0]  id_class;
  logic [7:0]  mccr_en;
  logic [7:0]  fu_ivalid;
  logic [7:0]  fu_done;
  logic        fu_exception;
  logic        fu_gpr_wen;
  logic [31:0] fu_gpr_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed results of the last transaction.
  int          o_lat, o_ivc, o_ivbad, o_decbad, o_stallbad, o_postbad;
  logic [2:0]  o_st;
  logic        o_wen;
  logic [31:0] o_wd;

  // Expected results from the model.
  int          e_lat, e_ivc;
  logic [2:0]  e_st;
  logic        e_wen;
  logic [31:0] e_wd;

  scarv_cop_dispatch #(.TIMEOUT(T)) dut (
    .g_clk           (g_clk),
    .g_reset         (g_reset),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_req_encoded (cpu_req_encoded),
    .cpu_rsp_valid   (cpu_rsp_valid),
    .cpu_rsp_ready   (cpu_rsp_ready),
    .cpu_rsp_status  (cpu_rsp_status),
    .cpu_rsp_wdata   (cpu_rsp_wdata),
    .cpu_rsp_wen     (cpu_rsp_wen),
    .cpu_flush       (cpu_flush),
    .id_encoded      (id_encoded),
    .id_exception    (id_exception),
    .id_class        (id_class),
    .mccr_en         (mccr_en),
    .fu_ivalid       (fu_ivalid),
    .fu_done         (fu_done),
    .fu_exception    (fu_exception),
    .fu_gpr_wen      (fu_gpr_wen),
    .fu_gpr_wdata    (fu_gpr_wdata)
  );

  always #5 g_clk = ~g_clk;

  // Reference: outcome of one instruction. dn is the EXEC cycle index (0 =
  // issue cycle) on which the unit's done strobe is presented, -1 for never.
  task automatic model(input logic [2:0] cls, input logic exc, input logic [7:0] en,
                       input int dn, input logic fexc, input logic fwen,
                       input logic [31:0] fwdata);
    e_wen = 1'b0;
    e_wd  = 32'd0;
    e_ivc = 0;
    if (exc) begin
      e_st = 3'd1; e_lat = 2;
    end else if (!en[cls]) begin
      e_st = 3'd2; e_lat = 2;
    end else if (dn >= 0 && dn < int'(T)) begin
      e_lat = 3 + dn;
      e_ivc = dn + 1;
      e_st  = fexc ? 3'd3 : 3'd0;
      e_wen = fwen && !fexc;
      e_wd  = e_wen ? fwdata : 32'd0;
    end else begin
      e_st = 3'd4; e_lat = 2 + int'(T); e_ivc = int'(T);
    end
  endtask

  // Drives one full request/response transaction. Starts and ends just after a
  // rising edge with the DUT in IDLE. Cycle 0 is the request handshake cycle.
  task automatic do_txn(input logic [31:0] insn, input logic [2:0] cls, input logic exc,
                        input logic [7:0] en, input int dn, input logic fexc,
                        input logic fwen, input logic [31:0] fwdata, input int stall);
    logic [7:0] other;
    o_lat = -1; o_ivc = 0; o_ivbad = 0; o_decbad = 0; o_stallbad = 0; o_postbad = 0;
    o_st = 3'd0; o_wen = 1'b0; o_wd = 32'd0;
    cpu_req_valid = 1'b1; cpu_req_encoded = insn;
    id_class = cls; id_exception = exc; mccr_en = en; cpu_rsp_ready = 1'b0;
    @(negedge g_clk);
    if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0) o_decbad++;
    @(posedge g_clk); #1;
    cpu_req_valid = 1'b0; cpu_req_encoded = $urandom;
    @(negedge g_clk);
    if (id_encoded !== insn || fu_ivalid !== 8'd0 || cpu_rsp_valid !== 1'b0) o_decbad++;
    @(posedge g_clk); #1;
    // Decoder outputs only matter during DECODE; scramble them afterwards.
    id_class = 3'($urandom); id_exception = 1'($urandom); mccr_en = 8'($urandom);
    for (int c = 2; c < 2 + int'(T) + 6; c++) begin
      other = 8'($urandom) & ~(8'd1 << cls);
      if (c - 2 == dn) begin
        fu_done = other | (8'd1 << cls);
        fu_exception = fexc; fu_gpr_wen = fwen; fu_gpr_wdata = fwdata;
      end else begin
        fu_done = other;
        fu_exception = 1'($urandom); fu_gpr_wen = 1'($urandom); fu_gpr_wdata = $urandom;
      end
      @(negedge g_clk);
      if (cpu_rsp_valid === 1'b1) begin
        o_lat = c; o_st = cpu_rsp_status; o_wen = cpu_rsp_wen; o_wd = cpu_rsp_wdata;
        break;
      end
      if (fu_ivalid !== 8'd0) begin
        o_ivc++;
        if (fu_ivalid !== (8'd1 << cls)) o_ivbad++;
      end
      @(posedge g_clk); #1;
    end
    fu_done = 8'd0;
    if (o_lat < 0) begin
      cpu_flush = 1'b1;
      @(posedge g_clk); #1;
      cpu_flush = 1'b0;
      return;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge g_clk); #1;
      cpu_req_valid = 1'b1; cpu_req_encoded = $urandom;
      @(negedge g_clk);
      if (cpu_rsp_valid !== 1'b1 || cpu_req_ready !== 1'b0 || cpu_rsp_status !== o_st ||
          cpu_rsp_wen !== o_wen || cpu_rsp_wdata !== o_wd || fu_ivalid !== 8'd0 ||
          id_encoded !== insn) o_stallbad++;
    end
    @(posedge g_clk); #1;
    cpu_req_valid = 1'b0; cpu_rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    cpu_rsp_ready = 1'b0;
    @(negedge g_clk);
    if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1 || id_encoded !== insn) o_postbad++;
    @(posedge g_clk); #1;
  endtask

  task automatic test_reset;
    g_reset = 1'b1;
    #1;
    n_checks++;
    if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 || cpu_rsp_status !== 3'd0 ||
        cpu_rsp_wen !== 1'b0 || cpu_rsp_wdata !== 32'd0 || fu_ivalid !== 8'd0 ||
        id_encoded !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vld=%b st=%0d wen=%b wd=%h iv=%h enc=%h want 1 0 0 0 0 0 0",
               cpu_req_ready, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_wdata,
               fu_ivalid, id_encoded);
    end
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    n_checks++;
    if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b want 1 0", cpu_req_ready, cpu_rsp_valid);
    end
    @(posedge g_clk); #1;
  endtask

  task automatic test_legal;
    do_txn(32'h1234_5678, 3'd2, 1'b0, 8'hFF, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
    n_checks++;
    if (o_lat !== 6) begin n_fail++; $display("FAIL legal_latency: got %0d want 6", o_lat); end
    n_checks++;
    if (o_ivc !== 4 || o_ivbad !== 0) begin
      n_fail++; $display("FAIL legal_ivalid: cycles=%0d bad=%0d want 4 0", o_ivc, o_ivbad);
    end
    n_checks++;
    if (o_st !== 3'd0 || o_wen !== 1'b1 || o_wd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL legal_rsp: st=%0d wen=%b wd=%h want 0 1 deadbeef", o_st, o_wen, o_wd);
    end
    n_checks++;
    if (o_decbad !== 0 || o_postbad !== 0) begin
      n_fail++; $display("FAIL legal_handshake: dec=%0d post=%0d want 0 0", o_decbad, o_postbad);
    end
  endtask

  task automatic test_illegal;
    do_txn(32'hFFFF_0001, 3'd6, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 32'h1111_1111, 0);
    n_checks++;
    if (o_lat !== 2 || o_st !== 3'd1 || o_wen !== 1'b0 || o_wd !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_rsp: lat=%0d st=%0d wen=%b wd=%h want 2 1 0 0",
               o_lat, o_st, o_wen, o_wd);
    end
    n_checks++;
    if (o_ivc !== 0) begin n_fail++; $display("FAIL illegal_ivalid: got %0d want 0", o_ivc); end
  endtask

  task automatic test_disabled;
    do_txn(32'h0000_0A5A, 3'd5, 1'b0, 8'hDF, 0, 1'b0, 1'b1, 32'h2222_2222, 0);
    n_checks++;
    if (o_lat !== 2 || o_st !== 3'd2 || o_wen !== 1'b0 || o_ivc !== 0) begin
      n_fail++;
      $display("FAIL disabled_rsp: lat=%0d st=%0d wen=%b iv=%0d want 2 2 0 0",
               o_lat, o_st, o_wen, o_ivc);
    end
  endtask

  task automatic test_fu_exc_timeout;
    do_txn(32'h0BAD_0BAD, 3'd1, 1'b0, 8'hFF, 1, 1'b1, 1'b1, 32'h3333_3333, 0);
    n_checks++;
    if (o_lat !== 4 || o_st !== 3'd3 || o_wen !== 1'b0 || o_wd !== 32'd0) begin
      n_fail++;
      $display("FAIL fu_exception_rsp: lat=%0d st=%0d wen=%b wd=%h want 4 3 0 0",
               o_lat, o_st, o_wen, o_wd);
    end
    do_txn(32'h7777_0000, 3'd7, 1'b0, 8'hFF, -1, 1'b0, 1'b1, 32'h4444_4444, 0);
    n_checks++;
    if (o_lat !== 6 || o_st !== 3'd4 || o_wen !== 1'b0 || o_ivc !== 4) begin
      n_fail++;
      $display("FAIL timeout_rsp: lat=%0d st=%0d wen=%b iv=%0d want 6 4 0 4",
               o_lat, o_st, o_wen, o_ivc);
    end
    do_txn(32'h5555_AAAA, 3'd0, 1'b0, 8'hFF, 3, 1'b0, 1'b0, 32'h5555_5555, 0);
    n_checks++;
    if (o_lat !== 6 || o_st !== 3'd0 || o_wen !== 1'b0 || o_wd !== 32'd0) begin
      n_fail++;
      $display("FAIL done_on_timeout: lat=%0d st=%0d wen=%b wd=%h want 6 0 0 0",
               o_lat, o_st, o_wen, o_wd);
    end
  endtask

  task automatic test_back_to_back;
    do_txn(32'hCAFE_0004, 3'd4, 1'b0, 8'hFF, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 10);
    n_checks++;
    if (o_st !== 3'd0 || o_wen !== 1'b1 || o_wd !== 32'hCAFE_F00D || o_lat !== 3) begin
      n_fail++;
      $display("FAIL backpressure_rsp: lat=%0d st=%0d wen=%b wd=%h want 3 0 1 cafef00d",
               o_lat, o_st, o_wen, o_wd);
    end
    n_checks++;
    if (o_stallbad !== 0 || o_postbad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: stall=%0d post=%0d want 0 0", o_stallbad, o_postbad);
    end
    do_txn(32'hCAFE_0005, 3'd3, 1'b0, 8'hFF, 2, 1'b0, 1'b1, 32'h0BEE_F00D, 0);
    n_checks++;
    if (o_lat !== 5 || o_wd !== 32'h0BEE_F00D || o_decbad !== 0) begin
      n_fail++;
      $display("FAIL after_backpressure: lat=%0d wd=%h dec=%0d want 5 0beef00d 0",
               o_lat, o_wd, o_decbad);
    end
  endtask

  task automatic test_flush;
    int seen;
    cpu_req_valid = 1'b1; cpu_req_encoded = 32'hF1F1_0003;
    id_class = 3'd3; id_exception = 1'b0; mccr_en = 8'hFF;
    @(posedge g_clk); #1;
    cpu_req_valid = 1'b0;
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    cpu_flush = 1'b1;
    @(negedge g_clk);
    n_checks++;
    if (fu_ivalid !== 8'h08) begin
      n_fail++; $display("FAIL flush_pre_ivalid: got %h want 08", fu_ivalid);
    end
    @(posedge g_clk); #1;
    cpu_flush = 1'b0;
    fu_done = 8'hFF; fu_gpr_wen = 1'b1;
    @(negedge g_clk);
    n_checks++;
    if (fu_ivalid !== 8'd0 || cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_exec: iv=%h rdy=%b vld=%b want 00 1 0",
               fu_ivalid, cpu_req_ready, cpu_rsp_valid);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge g_clk); #1;
      fu_done = 8'd0;
      @(negedge g_clk);
      if (cpu_rsp_valid !== 1'b0 || fu_ivalid !== 8'd0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_rsp: got %0d want 0", seen); end
    // Flush during DECODE.
    @(posedge g_clk); #1;
    cpu_req_valid = 1'b1; cpu_req_encoded = 32'hF1F1_0006;
    @(posedge g_clk); #1;
    cpu_req_valid = 1'b0; cpu_flush = 1'b1;
    @(posedge g_clk); #1;
    cpu_flush = 1'b0;
    @(negedge g_clk);
    n_checks++;
    if (fu_ivalid !== 8'd0 || cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_decode: iv=%h rdy=%b vld=%b want 00 1 0",
               fu_ivalid, cpu_req_ready, cpu_rsp_valid);
    end
    @(posedge g_clk); #1;
  endtask

  task automatic test_reset_mid_exec;
    cpu_req_valid = 1'b1; cpu_req_encoded = 32'hABCD_0002;
    id_class = 3'd2; id_exception = 1'b0; mccr_en = 8'hFF;
    @(posedge g_clk); #1;
    cpu_req_valid = 1'b0;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    n_checks++;
    if (fu_ivalid !== 8'h04) begin
      n_fail++; $display("FAIL reset_pre_ivalid: got %h want 04", fu_ivalid);
    end
    #2 g_reset = 1'b1;
    #1;
    n_checks++;
    if (fu_ivalid !== 8'd0 || cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 ||
        cpu_rsp_status !== 3'd0 || cpu_rsp_wen !== 1'b0 || cpu_rsp_wdata !== 32'd0 ||
        id_encoded !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_exec: iv=%h rdy=%b vld=%b st=%0d wen=%b wd=%h enc=%h want 00 1 0 0 0 0 0",
               fu_ivalid, cpu_req_ready, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen,
               cpu_rsp_wdata, id_encoded);
    end
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    fu_done = 8'h04;
    @(negedge g_clk);
    n_checks++;
    if (cpu_rsp_valid !== 1'b0 || fu_ivalid !== 8'd0 || cpu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after: vld=%b iv=%h rdy=%b want 0 00 1",
               cpu_rsp_valid, fu_ivalid, cpu_req_ready);
    end
    @(posedge g_clk); #1;
    fu_done = 8'd0;
  endtask

  task automatic test_random;
    logic [31:0] insn, fwd;
    logic [2:0]  cls;
    logic        exc, fexc, fwen;
    logic [7:0]  en;
    int          dn, stall;
    for (int i = 0; i < 60; i++) begin
      insn  = $urandom;
      cls   = 3'($urandom_range(0, 7));
      exc   = ($urandom_range(0, 7) == 0);
      en    = 8'($urandom);
      if ($urandom_range(0, 3) != 0) en = en | (8'd1 << cls);
      dn    = $urandom_range(0, 5);
      if (dn == 5) dn = -1;
      fexc  = ($urandom_range(0, 3) == 0);
      fwen  = 1'($urandom);
      fwd   = $urandom;
      stall = $urandom_range(0, 3);
      model(cls, exc, en, dn, fexc, fwen, fwd);
      do_txn(insn, cls, exc, en, dn, fexc, fwen, fwd, stall);
      n_checks++;
      if (o_lat !== e_lat || o_st !== e_st) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: lat=%0d st=%0d want lat=%0d st=%0d",
                 i, o_lat, o_st, e_lat, e_st);
      end
      n_checks++;
      if (o_wen !== e_wen || o_wd !== e_wd) begin
        n_fail++;
        $display("FAIL rand_gpr[%0d]: wen=%b wd=%h want wen=%b wd=%h",
                 i, o_wen, o_wd, e_wen, e_wd);
      end
      n_checks++;
      if (o_ivc !== e_ivc || o_ivbad !== 0) begin
        n_fail++;
        $display("FAIL rand_ivalid[%0d]: cycles=%0d bad=%0d want %0d 0",
                 i, o_ivc, o_ivbad, e_ivc);
      end
      n_checks++;
      if (o_decbad !== 0 || o_stallbad !== 0 || o_postbad !== 0) begin
        n_fail++;
        $display("FAIL rand_protocol[%0d]: dec=%0d stall=%0d post=%0d want 0 0 0",
                 i, o_decbad, o_stallbad, o_postbad);
      end
    end
  endtask

  initial begin
    g_reset = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_encoded = 32'd0; cpu_rsp_ready = 1'b0; cpu_flush = 1'b0;
    id_exception = 1'b0; id_class = 3'd0; mccr_en = 8'd0;
    fu_done = 8'd0; fu_exception = 1'b0; fu_gpr_wen = 1'b0; fu_gpr_wdata = 32'd0;
    test_reset;
    test_legal;
    test_illegal;
    test_disabled;
    test_fu_exc_timeout;
    test_back_to_back;
    test_flush;
    test_reset_mid_exec;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
